// File: rtl/utils_pkg.sv
// rtl/utils_pkg.sv - shared constants and buffer-state encoding for stream adapters
package utils_pkg;

  localparam int FIFO_RD_LATENCY = 1;

  // Encoding doubles as the buffered-word count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/stream_buf2.sv
// rtl/stream_buf2.sv - 2-entry registered buffer; head_data is a plain register
module stream_buf2
  import utils_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clear,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head_data
);

  buf_state_e            state;
  logic [DATA_WIDTH-1:0] tail_data;

  assign count = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      head_data <= '0;
      tail_data <= '0;
    end else if (clear) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_data <= push_data;
            state     <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail_data <= push_data;
              state     <= TWO;
            end
            2'b01:   state     <= EMPTY;
            2'b11:   head_data <= push_data;
            default: state     <= ONE;
          endcase
        end
        TWO: begin
          // Push without pop cannot happen here: the issue logic never over-commits.
          if (pop) begin
            head_data <= tail_data;
            if (push) tail_data <= push_data;
            else      state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a sync_fifo into a valid/ready stream at one word per cycle
module fifo_stream_reader
  import utils_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            level,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  logic       inflight;
  logic [1:0] count;
  logic       pop;
  logic [2:0] committed;

  assign m_valid = (count != 2'd0);
  assign pop     = m_valid & m_ready;
  assign level   = count;

  // Words held or on their way after this edge; a same-cycle pop frees a slot,
  // which is the m_ready -> fifo_rd_en path that keeps throughput at depth 2.
  assign committed  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = !rst && !flush && !fifo_empty && (committed < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  stream_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight & ~flush),
    .push_data(fifo_dout),
    .pop      (pop),
    .clear    (flush),
    .count    (count),
    .head_data(m_data)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - randomized bench with a word-level scoreboard of issued reads
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          flush;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [1:0]    level;
  logic [CW-1:0] xfer_cnt;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int            exp_cyc[$];
  int            cyc = 0;
  int            hs  = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .level     (level),
    .xfer_cnt  (xfer_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    src_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic step(input logic rdy, input logic fl);
    int            vis;
    int            pop_exp;
    logic          want_rd;
    logic          popped;
    logic [DW-1:0] w;
    m_ready = rdy;
    flush   = fl;
    #3;
    vis = 0;
    foreach (exp_cyc[i]) if (exp_cyc[i] <= cyc - 2) vis++;
    chk("level", level, vis);
    chk("m_valid", m_valid, vis != 0);
    if (vis != 0) chk("m_data", m_data, exp_q[0]);
    chk("xfer_cnt", xfer_cnt, hs % 16);
    pop_exp = (vis != 0 && rdy) ? 1 : 0;
    want_rd = !rst && !fl && src_q.size() != 0 && (exp_q.size() - pop_exp < 2);
    chk("fifo_rd_en", fifo_rd_en, want_rd);
    chk("outstanding_le_2", exp_q.size() <= 2, 1);
    if (m_valid && m_ready) begin
      hs++;
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(exp_cyc.pop_front());
      end
    end
    if (fl) begin
      exp_q.delete();
      exp_cyc.delete();
    end
    popped = 1'b0;
    w      = '0;
    if (fifo_rd_en && src_q.size() != 0) begin
      w = src_q.pop_front();
      exp_q.push_back(w);
      exp_cyc.push_back(cyc);
      popped = 1'b1;
    end
    @(posedge clk);
    #1;
    if (popped) fifo_dout = w;
    fifo_empty = (src_q.size() == 0);
    cyc++;
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_xfer_cnt"}, xfer_cnt, 0);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
  endtask

  task automatic rst_pulse();
    #2;
    rst = 1'b1;
    #1;
    reset_outputs("async_rst");
    exp_q.delete();
    exp_cyc.delete();
    hs = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (src_q.size() != 0 || exp_q.size() != 0); i++) step(1'b1, 1'b0);
    chk("drained", src_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    int            h0;
    int            n0;
    logic [DW-1:0] first;
    rst        = 1'b1;
    flush      = 1'b0;
    m_ready    = 1'b0;
    fifo_dout  = '0;
    fifo_empty = 1'b1;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    #1;
    reset_outputs("init_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    repeat (6) step(1'b1, 1'b0);
    chk("first3_xfer_cnt", xfer_cnt, 3);
    chk("first3_hs", hs, 3);

    h0 = hs;
    for (int i = 0; i < 100; i++) push_word(DW'($urandom));
    repeat (102) step(1'b1, 1'b0);
    chk("stream100_handshakes", hs - h0, 100);

    for (int i = 0; i < 5; i++) push_word(DW'($urandom));
    first = src_q[0];
    n0    = src_q.size();
    repeat (6) step(1'b0, 1'b0);
    chk("bp_pops", n0 - src_q.size(), 2);
    chk("bp_level", level, 2);
    chk("bp_head", m_data, first);
    repeat (10) step(1'b1, 1'b0);
    chk("bp_all_out", src_q.size() + exp_q.size(), 0);

    for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("pre_flush_level", level, 1);
    step(1'b0, 1'b1);
    chk("post_flush_level", level, 0);
    chk("post_flush_src_left", src_q.size(), 2);
    repeat (8) step(1'b1, 1'b0);
    chk("post_flush_done", src_q.size() + exp_q.size(), 0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(2) == 0) push_word(DW'($urandom));
      if (i == 700) rst_pulse();
      step(1'($urandom_range(3) != 0), 1'($urandom_range(39) == 0));
    end
    drain();

    rst_pulse();
    for (int i = 0; i < 17; i++) push_word(DW'($urandom));
    repeat (25) step(1'b1, 1'b0);
    chk("xfer_cnt_wrap17", xfer_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
